ballot_unit: RTL and testbench
==============================

Name: ballot_unit

Overview:
- Voter-side front end of the voting machine. It turns raw candidate buttons into the single-cycle, one-hot vote pulses that feed the per-candidate tally counters.
- Enforces one vote per authorisation from the poll officer, debounces the buttons, and rejects multi-button presses.
- Times out idle booths.
- Its vote outputs connect directly to the tally inputs a..e.

Parameters:
- NUM_CAND, 5, number of candidates; width of btn and vote.
- DEBOUNCE, 4, consecutive sampled cycles btn must hold the same value before it is accepted; must be >=2.
- TIMEOUT, 1000, cycles ARMED may sit with btn==0 before the authorisation is revoked.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  officer authorisation pulse; honoured only in IDLE.
- btn  in  NUM_CAND  raw candidate buttons, already synchronised to clk.
- vote  out  NUM_CAND  one-hot vote pulse, high for exactly 1 cycle per accepted ballot; bit i maps to candidate i.
- ready  out  1  high while state is ARMED or DEBOUNCE (booth lamp).
- reject  out  1  1-cycle pulse when a multi-button press is debounced.
- timeout  out  1  1-cycle pulse when an ARMED booth expires.
- voted_total  out  32  count of accepted ballots; saturates at 2^32-1.
- reject_cnt  out  16  count of rejected presses; saturates at 2^16-1.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; vote=0, ready=0, reject=0, timeout=0, voted_total=0, reject_cnt=0; internal sel, deb_cnt, timer and retry flag all 0.
- IDLE:
  - enable=1 -> ARMED, timer=0.
  - btn is ignored.
- ARMED:
  - btn==0: timer++. When timer==TIMEOUT-1, pulse timeout and go to IDLE.
  - btn!=0: sel<=btn, deb_cnt<=0 -> DEBOUNCE.
  - enable is ignored.
- DEBOUNCE (each edge):
  - btn!=sel -> ARMED, timer=0. This covers both a bounce and a changed selection.
  - btn==sel and deb_cnt<DEBOUNCE-1 -> deb_cnt++.
  - btn==sel and deb_cnt==DEBOUNCE-1:
    - sel is one-hot -> CAST.
    - otherwise pulse reject, reject_cnt++, retry=1 -> RELEASE.
- CAST:
  - vote=sel for this single cycle; voted_total++ (saturating); retry=0 -> RELEASE.
- RELEASE:
  - Waits for btn==0.
  - Then: retry=1 -> ARMED with timer=0; retry=0 -> IDLE.
  - A voter holding the button can never cast twice.
- Outputs vote, reject and timeout are registered, glitch-free, and never asserted together.
- Latency: btn first sampled nonzero at edge k (enter DEBOUNCE). If it holds through edge k+DEBOUNCE, the state is CAST after edge k+DEBOUNCE, and vote is high from that edge until edge k+DEBOUNCE+1.
- Simultaneous events:
  - enable during any non-IDLE state is ignored; no queuing.
  - Timeout expiry and a press on the same edge: the press wins, because btn!=0 takes the DEBOUNCE branch.
- Reset mid-ballot (e.g. in DEBOUNCE or CAST): the vote is aborted with no pulse, and the counters clear.
- Width rules: timer is sized ceil(log2(TIMEOUT)); deb_cnt is sized ceil(log2(DEBOUNCE)). The one-hot check is popcount(sel)==1.

Test Plan:
- Normal vote: rst low then high, enable pulse, btn=5'b00100 held 6 cycles -> exactly one cycle with vote=5'b00100, 4 cycles after DEBOUNCE entry; voted_total=1; state returns to IDLE after btn=0.
- Double press: enable, btn=5'b10001 held 5 cycles -> reject pulse, reject_cnt=1, vote never asserted. After btn=0 the booth is ARMED again; btn=5'b00001 -> vote=5'b00001, voted_total=1.
- Bounce: enable, btn toggles 00010/00000 every 2 cycles -> no vote, state stays ARMED/DEBOUNCE. Then hold 00010 for 4+ cycles -> one vote.
- Hold-over: after a cast, keep btn=01000 held 20 cycles and pulse enable during it -> no second vote, voted_total stays 1.
- Timeout: with TIMEOUT=8, enable and no btn -> timeout pulse on the 8th ARMED cycle, ready=0, state IDLE. A later btn press produces no vote.
- Async reset: assert rst=0 mid-DEBOUNCE, not aligned to clk -> all outputs 0 immediately. Release reset and press btn with no enable -> no vote.

Source files
------------

// File: rtl/ballot_unit.sv
// ballot_unit: voter-side front end of the voting machine.
// Turns raw (already synchronised) candidate buttons into single-cycle
// one-hot vote pulses for the tally counters. One ballot per officer
// authorisation, debounced buttons, multi-button presses rejected,
// idle booths time out.
//
// Handshake: there is no valid/ready pair here. `enable` is a level
// sampled on each rising edge and only has effect in IDLE; `vote`,
// `reject` and `timeout` are registered one-cycle pulses and never
// overlap; `ready` is a registered lamp, high while ARMED or DEBOUNCE.
//
// dbg_state encoding: 0=IDLE 1=ARMED 2=DEBOUNCE 3=CAST 4=RELEASE.
module ballot_unit #(
  parameter int NUM_CAND = 5,
  parameter int DEBOUNCE = 4,
  parameter int TIMEOUT  = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [NUM_CAND-1:0] btn,
  output logic [NUM_CAND-1:0] vote,
  output logic                ready,
  output logic                reject,
  output logic                timeout,
  output logic [31:0]         voted_total,
  output logic [15:0]         reject_cnt,
  output logic [2:0]          dbg_state
);

  localparam int TW = (TIMEOUT  > 1) ? $clog2(TIMEOUT)  : 1;
  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  localparam logic [TW-1:0]       TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [DW-1:0]       DEB_LAST   = DW'(DEBOUNCE - 1);
  localparam logic [TW-1:0]       TIMER_ONE  = TW'(1);
  localparam logic [DW-1:0]       DEB_ONE    = DW'(1);
  localparam logic [NUM_CAND-1:0] SEL_ONE    = NUM_CAND'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARMED    = 3'd1,
    S_DEBOUNCE = 3'd2,
    S_CAST     = 3'd3,
    S_RELEASE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_CAND-1:0] sel_q, sel_d;
  logic [DW-1:0]       deb_cnt_q, deb_cnt_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                retry_q, retry_d;
  logic [NUM_CAND-1:0] vote_q, vote_d;
  logic                ready_q, ready_d;
  logic                reject_q, reject_d;
  logic                timeout_q, timeout_d;
  logic [31:0]         voted_total_q, voted_total_d;
  logic [15:0]         reject_cnt_q, reject_cnt_d;

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
  logic sel_onehot;
  assign sel_onehot = (sel_q != '0) && ((sel_q & (sel_q - SEL_ONE)) == '0);

  // Next-state and next-output logic for the ballot sequence.
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    deb_cnt_d     = deb_cnt_q;
    timer_d       = timer_q;
    retry_d       = retry_q;
    vote_d        = '0;
    reject_d      = 1'b0;
    timeout_d     = 1'b0;
    voted_total_d = voted_total_q;
    reject_cnt_d  = reject_cnt_q;

    case (state_q)
      S_IDLE: begin
        // Buttons are ignored until the officer authorises the booth.
        if (enable) begin
          state_d = S_ARMED;
          timer_d = '0;
        end
      end

      S_ARMED: begin
        // A press takes priority over an expiring timer on the same edge.
        if (btn != '0) begin
          sel_d     = btn;
          deb_cnt_d = '0;
          state_d   = S_DEBOUNCE;
        end else if (timer_q == TIMER_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end

      S_DEBOUNCE: begin
        // Any change (bounce or new selection) restarts from ARMED.
        if (btn != sel_q) begin
          state_d = S_ARMED;
          timer_d = '0;
        end else if (deb_cnt_q != DEB_LAST) begin
          deb_cnt_d = deb_cnt_q + DEB_ONE;
        end else if (sel_onehot) begin
          // Vote is registered here so it is high for the whole CAST cycle.
          vote_d  = sel_q;
          state_d = S_CAST;
        end else begin
          reject_d = 1'b1;
          if (reject_cnt_q != 16'hFFFF) begin
            reject_cnt_d = reject_cnt_q + 16'd1;
          end
          retry_d = 1'b1;
          state_d = S_RELEASE;
        end
      end

      S_CAST: begin
        if (voted_total_q != 32'hFFFF_FFFF) begin
          voted_total_d = voted_total_q + 32'd1;
        end
        retry_d = 1'b0;
        state_d = S_RELEASE;
      end

      S_RELEASE: begin
        // Holding the button here can never produce a second ballot.
        if (btn == '0) begin
          if (retry_q) begin
            state_d = S_ARMED;
            timer_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_ARMED) || (state_d == S_DEBOUNCE);
  end

  // State and registered outputs; asynchronous active-low reset aborts any ballot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      sel_q         <= '0;
      deb_cnt_q     <= '0;
      timer_q       <= '0;
      retry_q       <= 1'b0;
      vote_q        <= '0;
      ready_q       <= 1'b0;
      reject_q      <= 1'b0;
      timeout_q     <= 1'b0;
      voted_total_q <= '0;
      reject_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      deb_cnt_q     <= deb_cnt_d;
      timer_q       <= timer_d;
      retry_q       <= retry_d;
      vote_q        <= vote_d;
      ready_q       <= ready_d;
      reject_q      <= reject_d;
      timeout_q     <= timeout_d;
      voted_total_q <= voted_total_d;
      reject_cnt_q  <= reject_cnt_d;
    end
  end

  assign vote        = vote_q;
  assign ready       = ready_q;
  assign reject      = reject_q;
  assign timeout     = timeout_q;
  assign voted_total = voted_total_q;
  assign reject_cnt  = reject_cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_ballot_unit.sv
// Bench for ballot_unit: directed ballots with an event scoreboard.
module tb_ballot_unit;

  localparam int NC = 5;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ARMED    = 3'd1;
  localparam logic [2:0] ST_DEBOUNCE = 3'd2;
  localparam logic [2:0] ST_RELEASE  = 3'd4;

  logic          clk;
  logic          rst;
  logic          enable;
  logic [NC-1:0] btn;
  logic [NC-1:0] vote;
  logic          ready;
  logic          reject;
  logic          timeout;
  logic [31:0]   voted_total;
  logic [15:0]   reject_cnt;
  logic [2:0]    dbg_state;

  int n_total = 0;
  int n_bad   = 0;

  // Scoreboard of output events {timeout, reject, vote}.
  logic [NC+1:0] exp_q[$];

  ballot_unit #(.NUM_CAND(NC), .DEBOUNCE(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .btn(btn),
    .vote(vote), .ready(ready), .reject(reject), .timeout(timeout),
    .voted_total(voted_total), .reject_cnt(reject_cnt), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: every output pulse must match the next expected event.
  always @(negedge clk) begin
    logic [NC+1:0] ev;
    ev = {timeout, reject, vote};
    if (rst && ev != '0) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_evt", 32'(ev), 32'd0);
      end else begin
        check_val("evt", 32'(ev), 32'(exp_q.pop_front()));
      end
    end
  end

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic authorise();
    enable = 1'b1;
    step(1);
    enable = 1'b0;
  endtask

  task automatic press(input logic [NC-1:0] v, input int hold);
    btn = v;
    step(hold);
    btn = '0;
    step(2);
  endtask

  task automatic push_vote(input logic [NC-1:0] v);
    exp_q.push_back({2'b00, v});
  endtask

  initial begin
    rst    = 1'b0;
    enable = 1'b0;
    btn    = '0;
    step(2);
    check_val("rst_vote",  32'(vote), 32'd0);
    check_val("rst_ready", 32'(ready), 32'd0);
    check_val("rst_total", voted_total, 32'd0);
    check_val("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b1;
    step(2);

    // Normal vote with exact latency.
    authorise();
    push_vote(5'b00100);
    btn = 5'b00100;
    step(1);
    check_val("n_deb_state", 32'(dbg_state), 32'(ST_DEBOUNCE));
    check_val("n_deb_ready", 32'(ready), 32'd1);
    step(3);
    check_val("n_vote_early", 32'(vote), 32'd0);
    step(1);
    check_val("n_vote", 32'(vote), 32'b00100);
    check_val("n_cast_ready", 32'(ready), 32'd0);
    step(1);
    check_val("n_vote_off", 32'(vote), 32'd0);
    check_val("n_rel_state", 32'(dbg_state), 32'(ST_RELEASE));
    check_val("n_total", voted_total, 32'd1);
    btn = '0;
    step(1);
    check_val("n_idle", 32'(dbg_state), 32'(ST_IDLE));

    // Double press is rejected, booth re-arms.
    authorise();
    exp_q.push_back({2'b01, 5'b00000});
    press(5'b10001, 6);
    check_val("d_rej_cnt", 32'(reject_cnt), 32'd1);
    check_val("d_rearm", 32'(dbg_state), 32'(ST_ARMED));
    check_val("d_ready", 32'(ready), 32'd1);
    check_val("d_total_same", voted_total, 32'd1);
    push_vote(5'b00001);
    press(5'b00001, 6);
    check_val("d_total", voted_total, 32'd2);
    check_val("d_idle", 32'(dbg_state), 32'(ST_IDLE));

    // Bouncing button never completes debounce.
    authorise();
    for (int i = 0; i < 4; i++) begin
      btn = 5'b00010;
      step(2);
      btn = '0;
      step(2);
    end
    check_val("b_ready", 32'(ready), 32'd1);
    check_val("b_total_same", voted_total, 32'd2);
    push_vote(5'b00010);
    press(5'b00010, 6);
    check_val("b_total", voted_total, 32'd3);

    // Held button plus enable during hold: single vote only.
    authorise();
    push_vote(5'b01000);
    btn = 5'b01000;
    step(10);
    enable = 1'b1;
    step(1);
    enable = 1'b0;
    step(9);
    check_val("h_state", 32'(dbg_state), 32'(ST_RELEASE));
    btn = '0;
    step(2);
    check_val("h_total", voted_total, 32'd4);
    check_val("h_idle", 32'(dbg_state), 32'(ST_IDLE));

    // Timeout on the 8th ARMED cycle.
    authorise();
    exp_q.push_back({2'b10, 5'b00000});
    step(7);
    check_val("t_early", 32'(timeout), 32'd0);
    check_val("t_ready_pre", 32'(ready), 32'd1);
    step(1);
    check_val("t_pulse", 32'(timeout), 32'd1);
    check_val("t_ready", 32'(ready), 32'd0);
    check_val("t_idle", 32'(dbg_state), 32'(ST_IDLE));
    step(1);
    check_val("t_pulse_off", 32'(timeout), 32'd0);
    press(5'b00001, 8);
    check_val("t_no_vote", voted_total, 32'd4);
    check_val("t_rej_cnt", 32'(reject_cnt), 32'd1);

    // Asynchronous reset mid-debounce.
    authorise();
    btn = 5'b00100;
    step(2);
    check_val("r_pre_state", 32'(dbg_state), 32'(ST_DEBOUNCE));
    #2 rst = 1'b0;
    #1;
    check_val("r_vote", 32'(vote), 32'd0);
    check_val("r_ready", 32'(ready), 32'd0);
    check_val("r_total", voted_total, 32'd0);
    check_val("r_rej", 32'(reject_cnt), 32'd0);
    check_val("r_state", 32'(dbg_state), 32'(ST_IDLE));
    btn = '0;
    step(1);
    rst = 1'b1;
    step(1);
    press(5'b00100, 8);
    check_val("r_no_vote", voted_total, 32'd0);
    check_val("r_still_idle", 32'(dbg_state), 32'(ST_IDLE));

    step(3);
    check_val("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
